pipe_mult_float: RTL
====================

PIPE_MULT_FLOAT -- requirements
Module: pipe_mult_float

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (legal 4..8).
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width (legal 3..23).
REQ-003 SHALL have parameter STAGES, default 3, pipeline depth in cycles (legal 2..4).
REQ-004 SHALL have port clk  input  1  the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 SHALL have port in_valid  input  1  operand pair valid.
REQ-007 SHALL have port in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 SHALL have port data1  input  1+EXP_W+MAN_W  operand A as {sign, exp, man}.
REQ-009 SHALL have port data2  input  1+EXP_W+MAN_W  operand B as {sign, exp, man}.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port result  output  1+EXP_W+MAN_W  product as {sign, exp, man}.
REQ-013 SHALL have port flags  output  2  {overflow, underflow} qualified by out_valid.

Function
REQ-014 SHALL transfer an input when in_valid and in_ready are both high, and an output when out_valid and out_ready are both high.
REQ-015 SHALL drive in_ready = !out_valid || out_ready, with all stages advancing together when in_ready is high; result, out_valid and flags SHALL hold while stalled.
REQ-016 SHALL present each accepted pair's result exactly STAGES cycles after acceptance when out_ready is held high, in order, with no loss or duplication.
REQ-017 SHALL pass bubbles through as invalid stage slots without collapsing them.
REQ-018 SHALL compute sign = sign(A) XOR sign(B).
REQ-019 SHALL use bias = 2^(EXP_W-1)-1 and the significand product {1,manA}*{1,manB} of width 2*MAN_W+2, normalised by one bit when the MSB is set.
REQ-020 SHALL treat any operand with exp==0 as zero (denormals flushed), returning +0 with both flags low.
REQ-021 SHALL, when the post-rounding exponent is >= 2^EXP_W-1 or either operand has exp all-ones, return {sign, 2^EXP_W-2, all-ones man} and set overflow.
REQ-022 SHALL, when the post-rounding exponent is <= 0 and neither operand is zero, return +0 and set underflow.
REQ-023 SHALL renormalise when rounding carries out of the mantissa, incrementing the exponent before the overflow check.
REQ-024 SHALL give overflow priority over underflow, and zero-operand handling priority over both.

Reset
REQ-025 SHALL, while rst_n is low, clear all stage-valid bits so out_valid=0, result=0 and flags=0; in_ready SHALL be 1 after reset.
REQ-026 SHALL discard in-flight operations on reset mid-operation; none SHALL emerge after release.

Configuration
REQ-027 SHALL, with MULT_FLOAT_RNE_EN defined, round to nearest-even using guard and sticky bits from the discarded product bits.
REQ-028 SHALL, without MULT_FLOAT_RNE_EN, truncate the discarded bits, with latency and handshake unchanged.

Structure
REQ-029 SHALL take the bias function, the field-slicing widths and the flag bit indices from the shared package mult_float_pkg.
REQ-030 SHALL place normalise, round and saturate logic in the combinational sub-module mult_float_round, instantiated in the last stage.

Verification
REQ-031 SHALL cover 0x3C00*0x3C00 -> 0x3C00 and 0x4000*0xC200 -> 0xC600, both with flags=00 (default parameters).
REQ-032 SHALL cover 0x3C01*0x3E00 -> 0x3E02 with MULT_FLOAT_RNE_EN, and -> 0x3E01 without it.
REQ-033 SHALL cover 0x7BFF*0x4000 -> 0x7BFF with flags=10, and 0x0400*0x0400 -> 0x0000 with flags=01.
REQ-034 SHALL cover 0x0000*0x5000 -> 0x0000 and 0x7C00*0x3C00 -> 0x7BFF with flags=10.
REQ-035 SHALL cover 8 back-to-back pairs with out_ready low for 5 cycles mid-stream -> all 8 results in order, in_ready low while the output is held, and first-result latency = STAGES.
REQ-036 SHALL cover rst_n asserted with 2 operations in flight -> out_valid=0 immediately, and no stale result after release.

Source files
------------

// File: rtl/mult_float_pkg.sv
// rtl/mult_float_pkg.sv - shared widths, bias and flag indices for the float multiplier
// Helpers are constant functions so each instance can size itself from EXP_W/MAN_W.
package mult_float_pkg;

  localparam int FLAGS_W  = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {sign, exp, man}
  function automatic int word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  // significand product {1,manA}*{1,manB}
  function automatic int prod_w(input int man_w);
    return 2 * man_w + 2;
  endfunction

  // signed working exponent: covers 2*(2^E-1)-bias+2 down to 2-bias
  function automatic int exp_calc_w(input int exp_w);
    return exp_w + 3;
  endfunction

endpackage

// File: rtl/mult_float_round.sv
// rtl/mult_float_round.sv - normalise, round and saturate the raw significand product
// Optional feature macro: MULT_FLOAT_RNE_EN (round to nearest-even; truncate otherwise).
// Ports:
//   sign    - product sign
//   exp_sum - expA + expB - bias, signed, before normalisation
//   prod    - {1,manA}*{1,manB}
//   zero    - an operand had exp==0
//   sat     - an operand had exp all-ones
//   result  - packed {sign, exp, man}
//   flags   - {overflow, underflow}
module mult_float_round
  import mult_float_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                               sign,
  input  logic signed [exp_calc_w(EXP_W)-1:0] exp_sum,
  input  logic [prod_w(MAN_W)-1:0]           prod,
  input  logic                               zero,
  input  logic                               sat,
  output logic [word_w(EXP_W, MAN_W)-1:0]    result,
  output logic [FLAGS_W-1:0]                 flags
);

  localparam int XW = exp_calc_w(EXP_W);
  localparam int PW = prod_w(MAN_W);
  localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic [EXP_W-1:0]     SAT_EXP  = EXP_W'((1 << EXP_W) - 2);

  logic                 norm_shift;
  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     mant;
  logic                 rnd_inc;
  logic [MAN_W:0]       mant_r;
  logic signed [XW-1:0] exp_r;
  logic                 unused_lead;

  // Product lies in [1,4): shift left when below 2 so the hidden one sits at PW-1.
  assign norm_shift  = prod[PW-1];
  assign norm        = norm_shift ? prod : (prod << 1);
  assign mant        = norm[PW-2 -: MAN_W];
  assign unused_lead = norm[PW-1];

`ifdef MULT_FLOAT_RNE_EN
  logic guard;
  logic sticky;
  assign guard   = norm[MAN_W];
  assign sticky  = |norm[MAN_W-1:0];
  assign rnd_inc = guard & (sticky | mant[0]);
`else
  logic unused_discard;
  assign unused_discard = ^norm[MAN_W:0];
  assign rnd_inc        = 1'b0;
`endif

  // A carry out of the mantissa leaves mant_r[MAN_W-1:0] all zero, i.e. 1.0 at exp+1.
  assign mant_r = {1'b0, mant} + (MAN_W + 1)'(rnd_inc);
  assign exp_r  = exp_sum + XW'(norm_shift) + XW'(mant_r[MAN_W]);

  always_comb begin
    result = '0;
    flags  = '0;
    if (zero) begin
      result = '0;
    end else if (sat || (exp_r >= EXP_MAX)) begin
      result          = {sign, SAT_EXP, {MAN_W{1'b1}}};
      flags[FLAG_OVF] = 1'b1;
    end else if (exp_r <= EXP_ZERO) begin
      flags[FLAG_UNF] = 1'b1;
    end else begin
      result = {sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/pipe_mult_float.sv
// rtl/pipe_mult_float.sv - STAGES-deep pipelined floating-point multiplier with valid/ready
// Optional feature macro: MULT_FLOAT_RNE_EN (handled inside mult_float_round).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid, in_ready  - operand handshake; in_ready = !out_valid || out_ready
//   data1, data2        - operands {sign, exp, man}
//   out_valid, out_ready- result handshake
//   result, flags       - product and {overflow, underflow}
// Stage 1 registers the unpacked exponent sum and significand product; middle
// stages only delay; the last stage registers the output of mult_float_round.
module pipe_mult_float
  import mult_float_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10,
  parameter int STAGES = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [word_w(EXP_W, MAN_W)-1:0] data1,
  input  logic [word_w(EXP_W, MAN_W)-1:0] data2,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [word_w(EXP_W, MAN_W)-1:0] result,
  output logic [FLAGS_W-1:0]              flags
);

  localparam int WW = word_w(EXP_W, MAN_W);
  localparam int XW = exp_calc_w(EXP_W);
  localparam int PW = prod_w(MAN_W);
  localparam int LS = STAGES - 1;

  logic [EXP_W-1:0]     exp_a, exp_b;
  logic [MAN_W-1:0]     man_a, man_b;
  logic signed [XW-1:0] exp_sum_in;
  logic [PW-1:0]        prod_in;

  logic                 pipe_valid [1:LS];
  logic                 pipe_sign  [1:LS];
  logic signed [XW-1:0] pipe_exp   [1:LS];
  logic [PW-1:0]        pipe_prod  [1:LS];
  logic                 pipe_zero  [1:LS];
  logic                 pipe_sat   [1:LS];

  logic [WW-1:0]        rnd_result;
  logic [FLAGS_W-1:0]   rnd_flags;

  assign exp_a      = data1[WW-2 -: EXP_W];
  assign exp_b      = data2[WW-2 -: EXP_W];
  assign man_a      = data1[MAN_W-1:0];
  assign man_b      = data2[MAN_W-1:0];
  assign exp_sum_in = XW'(exp_a) + XW'(exp_b) - XW'(bias(EXP_W));
  assign prod_in    = PW'({1'b1, man_a}) * PW'({1'b1, man_b});

  assign in_ready = !out_valid || out_ready;

  mult_float_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .sign    (pipe_sign[LS]),
    .exp_sum (pipe_exp[LS]),
    .prod    (pipe_prod[LS]),
    .zero    (pipe_zero[LS]),
    .sat     (pipe_sat[LS]),
    .result  (rnd_result),
    .flags   (rnd_flags)
  );

  // Whole pipe advances in lock-step; a stalled output freezes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LS; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_sign[i]  <= 1'b0;
        pipe_exp[i]   <= '0;
        pipe_prod[i]  <= '0;
        pipe_zero[i]  <= 1'b0;
        pipe_sat[i]   <= 1'b0;
      end
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (in_ready) begin
      pipe_valid[1] <= in_valid;
      pipe_sign[1]  <= data1[WW-1] ^ data2[WW-1];
      pipe_exp[1]   <= exp_sum_in;
      pipe_prod[1]  <= prod_in;
      pipe_zero[1]  <= (exp_a == '0) || (exp_b == '0);
      pipe_sat[1]   <= (&exp_a) || (&exp_b);
      for (int i = 2; i <= LS; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_sign[i]  <= pipe_sign[i-1];
        pipe_exp[i]   <= pipe_exp[i-1];
        pipe_prod[i]  <= pipe_prod[i-1];
        pipe_zero[i]  <= pipe_zero[i-1];
        pipe_sat[i]   <= pipe_sat[i-1];
      end
      out_valid <= pipe_valid[LS];
      result    <= rnd_result;
      flags     <= rnd_flags;
    end
  end

endmodule
